// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and FSM encoding for the clearable dual-port data RAM.
package ram_pkg;
  localparam int RDW_READ_OLD      = 0;
  localparam int RDW_WRITE_THROUGH = 1;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
endpackage

// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: two-master RAM bus (port A = CPU, port B = debugger/DMA) plus clear busy flag.
interface ram_dp_clr_if #(
  parameter int ram_width  = 9,
  parameter int data_width = 8
);
  logic                  busy;
  logic                  a_re, a_we, b_re, b_we;
  logic [ram_width-1:0]  a_addr, b_addr;
  logic [data_width-1:0] a_wdata, a_rdata, b_wdata, b_rdata;
  modport master (
    input  busy, a_rdata, b_rdata,
    output a_re, a_we, a_addr, a_wdata, b_re, b_we, b_addr, b_wdata
  );
  modport slave (
    output busy, a_rdata, b_rdata,
    input  a_re, a_we, a_addr, a_wdata, b_re, b_we, b_addr, b_wdata
  );
endinterface

// File: rtl/ram_dp_core.sv
// ram_dp_core: bare true dual-port array, A wins same-address writes, registered reads.
module ram_dp_core
  import ram_pkg::*;
#(
  parameter int ram_width  = 9,
  parameter int data_width = 8,
  parameter int rdw_mode   = RDW_READ_OLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_a_re,
  input  logic                  i_a_we,
  input  logic [ram_width-1:0]  i_a_addr,
  input  logic [data_width-1:0] i_a_wdata,
  output logic [data_width-1:0] o_a_rdata,
  input  logic                  i_b_re,
  input  logic                  i_b_we,
  input  logic [ram_width-1:0]  i_b_addr,
  input  logic [data_width-1:0] i_b_wdata,
  output logic [data_width-1:0] o_b_rdata
);
  logic [data_width-1:0] r_mem [2**ram_width];
  logic [data_width-1:0] r_a_rdata, r_b_rdata;
  logic                  w_b_wr;
  assign w_b_wr    = i_b_we && !(i_a_we && i_a_addr == i_b_addr);
  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (w_b_wr) r_mem[i_b_addr] <= i_b_wdata;
  end
  // Cross-port collisions always see the old word since r_mem is read before the edge updates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (i_a_re) r_a_rdata <= (rdw_mode == RDW_WRITE_THROUGH && i_a_we) ? i_a_wdata : r_mem[i_a_addr];
      if (i_b_re) r_b_rdata <= (rdw_mode == RDW_WRITE_THROUGH && w_b_wr) ? i_b_wdata : r_mem[i_b_addr];
    end
  end
endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port data RAM with optional post-reset clear sequencer and busy flag.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                  ram_width      = 9,
  parameter int                  data_width     = 8,
  parameter int                  rdw_mode       = RDW_READ_OLD,
  parameter bit                  clear_on_reset = 1'b1,
  parameter logic [data_width-1:0] clear_value  = '0
) (
  input logic         clk,
  input logic         rst,
  ram_dp_clr_if.slave bus
);
  state_t                r_state;
  logic [ram_width-1:0]  r_cnt;
  logic                  r_busy;
  logic                  w_clr;
  logic                  w_a_we;
  logic [ram_width-1:0]  w_a_addr;
  logic [data_width-1:0] w_a_wdata;
  assign w_clr     = r_state == ST_CLEAR;
  assign bus.busy  = r_busy;
  // The clear engine owns port A while clearing; all master requests are masked.
  assign w_a_we    = w_clr ? 1'b1 : bus.a_we;
  assign w_a_addr  = w_clr ? r_cnt : bus.a_addr;
  assign w_a_wdata = w_clr ? clear_value : bus.a_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= clear_on_reset ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= clear_on_reset;
    end else if (w_clr) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
  ram_dp_core #(
    .ram_width (ram_width),
    .data_width(data_width),
    .rdw_mode  (rdw_mode)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_a_re   (!w_clr && bus.a_re),
    .i_a_we   (w_a_we),
    .i_a_addr (w_a_addr),
    .i_a_wdata(w_a_wdata),
    .o_a_rdata(bus.a_rdata),
    .i_b_re   (!w_clr && bus.b_re),
    .i_b_we   (!w_clr && bus.b_we),
    .i_b_addr (bus.b_addr),
    .i_b_wdata(bus.b_wdata),
    .o_b_rdata(bus.b_rdata)
  );
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: scoreboard bench over read-old, write-through and no-clear RAM instances.
module tb_ram_dp_clr;
  typedef struct {
    int          src;
    logic [15:0] val;
    string       name;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic       a_re8, a_we8, b_re8, b_we8, a_re16, a_we16, b_re16, b_we16;
  logic [3:0] a_addr8, b_addr8, a_addr16, b_addr16;
  logic [7:0] a_wd8, b_wd8;
  logic [15:0] a_wd16, b_wd16;
  logic [5:0] rd_pend = '0;
  logic [15:0] w_rd [6];
  exp_t q[$];
  int checks = 0, errors = 0, n;
  always #5 clk = ~clk;
  ram_dp_clr_if #(.ram_width(4), .data_width(8))  if0 ();
  ram_dp_clr_if #(.ram_width(4), .data_width(8))  if1 ();
  ram_dp_clr_if #(.ram_width(4), .data_width(16)) if2 ();
  assign {if0.a_re, if0.a_we, if0.a_addr, if0.a_wdata} = {a_re8, a_we8, a_addr8, a_wd8};
  assign {if0.b_re, if0.b_we, if0.b_addr, if0.b_wdata} = {b_re8, b_we8, b_addr8, b_wd8};
  assign {if1.a_re, if1.a_we, if1.a_addr, if1.a_wdata} = {a_re8, a_we8, a_addr8, a_wd8};
  assign {if1.b_re, if1.b_we, if1.b_addr, if1.b_wdata} = {b_re8, b_we8, b_addr8, b_wd8};
  assign {if2.a_re, if2.a_we, if2.a_addr, if2.a_wdata} = {a_re16, a_we16, a_addr16, a_wd16};
  assign {if2.b_re, if2.b_we, if2.b_addr, if2.b_wdata} = {b_re16, b_we16, b_addr16, b_wd16};
  assign w_rd[0] = {8'h00, if0.a_rdata};
  assign w_rd[1] = {8'h00, if0.b_rdata};
  assign w_rd[2] = {8'h00, if1.a_rdata};
  assign w_rd[3] = {8'h00, if1.b_rdata};
  assign w_rd[4] = if2.a_rdata;
  assign w_rd[5] = if2.b_rdata;
  ram_dp_clr #(.ram_width(4), .data_width(8), .rdw_mode(0), .clear_on_reset(1'b1), .clear_value(8'hA5))
    u_old (.clk(clk), .rst(rst), .bus(if0));
  ram_dp_clr #(.ram_width(4), .data_width(8), .rdw_mode(1), .clear_on_reset(1'b1), .clear_value(8'hA5))
    u_wt (.clk(clk), .rst(rst), .bus(if1));
  ram_dp_clr #(.ram_width(4), .data_width(16), .rdw_mode(0), .clear_on_reset(1'b0), .clear_value(16'h0000))
    u_nc (.clk(clk), .rst(rst), .bus(if2));
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input int src, input logic [15:0] v, input string name);
    q.push_back('{src, v, name});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_clear(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (if0.busy && cnt < 100);
  endtask
  always @(posedge clk) rd_pend <= {b_re16, a_re16, b_re8, a_re8, b_re8, a_re8};
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int s = 0; s < 6; s++)
      if (rd_pend[s]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got read on src %0d expected none", s);
        end else begin
          e = q.pop_front();
          chk($sformatf("%s_src%0d", e.name, s), w_rd[s], (e.src == s) ? e.val : 16'hxxxx);
        end
      end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    {a_re8, a_we8, b_re8, b_we8, a_re16, a_we16, b_re16, b_we16} = '0;
    {a_addr8, b_addr8, a_addr16, b_addr16, a_wd8, b_wd8, a_wd16, b_wd16} = '0;
    repeat (2) step();
    for (int s = 0; s < 6; s++) chk($sformatf("rst_rdata%0d", s), w_rd[s], 16'h0);
    chk("rst_busy_old", {15'h0, if0.busy}, 16'h1);
    chk("rst_busy_wt", {15'h0, if1.busy}, 16'h1);
    chk("rst_busy_nc", {15'h0, if2.busy}, 16'h0);
    rst = 1'b0;
    wait_clear(n);
    chk("clear_len", n[15:0], 16'd16);
    chk("clear_done_wt", {15'h0, if1.busy}, 16'h0);
    chk("busy_nc", {15'h0, if2.busy}, 16'h0);
    a_we16 = 1'b1; a_addr16 = 4'd2; a_wd16 = 16'hBEEF;
    step();
    a_we16 = 1'b0; b_re16 = 1'b1; b_addr16 = 4'd2;
    push(5, 16'hBEEF, "nc_wr_rd");
    step();
    b_re16 = 1'b0;
    a_we8 = 1'b1; a_addr8 = 4'd5; a_wd8 = 8'h3C;
    step();
    a_we8 = 1'b0; a_re8 = 1'b1;
    push(0, 16'h3C, "wr_then_rd"); push(2, 16'h3C, "wr_then_rd");
    step();
    a_re8 = 1'b0; a_we8 = 1'b1; a_addr8 = 4'd7; a_wd8 = 8'h22;
    step();
    a_wd8 = 8'h11; a_re8 = 1'b1; b_re8 = 1'b1; b_addr8 = 4'd7;
    push(0, 16'h22, "rdw_old"); push(1, 16'h22, "cross_old");
    push(2, 16'h11, "rdw_wt");  push(3, 16'h22, "cross_old");
    step();
    a_we8 = 1'b0; b_re8 = 1'b0;
    push(0, 16'h11, "rdw_after"); push(2, 16'h11, "rdw_after");
    step();
    a_re8 = 1'b0; a_we8 = 1'b1; b_we8 = 1'b1; a_addr8 = 4'd3; b_addr8 = 4'd3; a_wd8 = 8'hF0; b_wd8 = 8'h0F;
    step();
    a_we8 = 1'b0; b_we8 = 1'b0; a_re8 = 1'b1; b_re8 = 1'b1;
    for (int s = 0; s < 4; s++) push(s, 16'hF0, "a_wins");
    step();
    a_re8 = 1'b0; b_re8 = 1'b0;
    step();
    rst = 1'b1;
    #1;
    for (int s = 0; s < 6; s++) chk($sformatf("async_rst_rdata%0d", s), w_rd[s], 16'h0);
    chk("async_rst_busy", {15'h0, if0.busy}, 16'h1);
    step();
    rst = 1'b0;
    repeat (9) step();
    chk("mid_clear_busy", {15'h0, if0.busy}, 16'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {15'h0, if1.busy}, 16'h1);
    chk("mid_rst_rdata_a", w_rd[0], 16'h0);
    chk("mid_rst_rdata_b", w_rd[3], 16'h0);
    step();
    rst = 1'b0;
    a_we8 = 1'b1; a_addr8 = 4'd2; a_wd8 = 8'h77; a_re8 = 1'b0;
    b_we8 = 1'b1; b_addr8 = 4'd9; b_wd8 = 8'h66;
    wait_clear(n);
    a_we8 = 1'b0; b_we8 = 1'b0;
    chk("reclear_len", n[15:0], 16'd16);
    for (int i = 0; i < 16; i++) begin
      b_re8 = 1'b1; b_addr8 = 4'(i);
      push(1, 16'hA5, $sformatf("clr_a%0d", i)); push(3, 16'hA5, $sformatf("clr_a%0d", i));
      step();
    end
    b_re8 = 1'b0;
    repeat (3) step();
    chk("sb_drained", 16'(q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
